dcache_ctrl_burst: RTL
======================

// Module: dcache_ctrl_burst
// PURPOSE
//  Parametrised data-cache control FSM for the coherent memory hierarchy; sits between the
//  dcache datapath (tag/data arrays) and the bus/coherence controller.
//  Sequences multi-word victim writebacks, line fills, snoop-triggered writebacks and the
//  end-of-program flush. Generalises block size and flush range, and adds snoop-during-flush.
//  Owns its own word and flush-index counters.
// PARAMETERS
//  WORDS_PER_BLK  2  words per cache block; power of two, >=2
//  SETS           8  number of sets
//  WAYS           2  associativity; flush walks SETS*WAYS lines
// PORTS
//  CLK        in   1   clock; all state changes on rising edge
//  nRST       in   1   reset; synchronous, active-low
//  dmemREN    in   1   datapath load request
//  dmemWEN    in   1   datapath store request
//  dhit       in   1   tag match on current request
//  dirty      in   1   dirty bit of selected line (victim, snoop target or flush_idx line)
//  flush      in   1   datapath halt request; level, held until halt
//  dwait      in   1   memory busy; transfer word accepted when low
//  ccwait     in   1   coherence controller owns the bus
//  ccwrite    in   1   with ccwait: snoop demands writeback + invalidate of snooped line
//  dREN       out  1   memory read (fill)
//  dWEN       out  1   memory write (writeback)
//  word_idx   out  $clog2(WORDS_PER_BLK)  word offset of current transfer
//  fill_we    out  1   write returned word into data array (FILL & ~dwait)
//  line_clr   out  1   one-cycle pulse: clear valid+dirty (after snoop WB) or dirty (after victim/flush WB)
//  flush_idx  out  $clog2(SETS*WAYS)+1  line under flush, {set,way} flat index
//  flushing   out  1   high in every flush state
//  halt       out  1   flush complete; sticky
//  busy       out  1   state != IDLE and != HALT
// BEHAVIOUR
//  Reset: state IDLE, word_idx 0, flush_idx 0; all outputs 0. Sync reset mid-burst aborts
//   the burst on that edge, no line_clr.
//  Outputs decoded from registered state and counters only (Moore), except fill_we,
//   which is also gated by dwait.
//  miss = (dmemREN|dmemWEN) & ~dhit; snoop = ccwait & ccwrite.
//  IDLE priority: snoop -> SNP_WB (if dirty; else line_clr pulse, stay IDLE);
//   miss & ~ccwait -> dirty ? WB : FILL; flush -> FL_CHK; else IDLE.
//  WB: dWEN=1. FILL: dREN=1. SNP_WB: dWEN=1. word_idx increments on each ~dwait.
//   Last word = (word_idx==WORDS_PER_BLK-1) & ~dwait; at last word word_idx wraps to 0.
//   WB last -> FILL (line_clr). FILL last -> IDLE. SNP_WB last -> IDLE (line_clr).
//   dwait high: hold state and word_idx.
//  FL_CHK (flushing): flush_idx==SETS*WAYS -> HALT; snoop -> FL_SNP;
//   dirty -> FL_WB; else FL_NEXT.
//  FL_WB: dWEN=1, words as WB; last -> FL_NEXT (line_clr).
//  FL_SNP: as SNP_WB; last -> FL_CHK; flush_idx unchanged.
//  FL_NEXT: flush_idx+1 -> FL_CHK.
//  HALT: halt=1; exits only via reset.
//  Snoop in IDLE preempts a same-cycle miss; miss re-evaluated next IDLE cycle.
//  Snoop arriving mid WB/FILL/FL_WB is not serviced until the burst ends
//   (bus is granted to this cache).
//  No combinational path from dwait to dREN/dWEN.
// STRUCTURE
//  Package cache_cu_pkg: dcache_state_t enum (IDLE, WB, FILL, SNP_WB, FL_CHK, FL_WB,
//   FL_SNP, FL_NEXT, HALT); functions widx_w(WORDS_PER_BLK) and fidx_w(SETS,WAYS).
//  Sub-module burst_word_ctr: word_idx counter with en/clr/last ports, parametrised by
//   WORDS_PER_BLK. Flush counter stays inline.
// TESTING
//  1. Clean miss, WORDS_PER_BLK=4, dwait low 1 cycle per word -> FILL 4 words, fill_we x4,
//     word_idx 0..3, IDLE.
//  2. Dirty miss, dwait high 2 cycles on word 1 -> dWEN words 0-3 with word 1 held,
//     line_clr, FILL, IDLE.
//  3. Snoop + miss same cycle, line dirty -> SNP_WB first, line_clr, then miss serviced.
//  4. Flush SETS=8,WAYS=2, lines 3 and 15 dirty -> exactly 2 FL_WB bursts, flush_idx
//     reaches 16, halt=1 and sticky.
//  5. Snoop during FL_CHK at flush_idx=5 -> FL_SNP, flush_idx stays 5, walk resumes.
//  6. nRST low mid-WB word 2 -> next edge IDLE, word_idx 0, dWEN 0, no line_clr.

Source files
------------

// File: rtl/cache_cu_pkg.sv
// Shared types and width helpers for the data-cache control unit.
package cache_cu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WB,
    FILL,
    SNP_WB,
    FL_CHK,
    FL_WB,
    FL_SNP,
    FL_NEXT,
    HALT
  } dcache_state_t;

  // Width of the word-within-block index (block size is a power of two, >= 2).
  function automatic int widx_w(input int words_per_blk);
    return $clog2(words_per_blk);
  endfunction

  // Width of the flush line index; one extra bit so the index can reach SETS*WAYS.
  function automatic int fidx_w(input int sets, input int ways);
    return $clog2(sets * ways) + 1;
  endfunction

endpackage

// File: rtl/burst_word_ctr.sv
// Word offset counter for multi-word bus bursts. Advances on each accepted
// word, wraps to zero after the last word of the block.
module burst_word_ctr
  import cache_cu_pkg::*;
#(
  parameter int WORDS_PER_BLK = 2
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             en,
  input  logic                             clr,
  output logic [widx_w(WORDS_PER_BLK)-1:0] word_idx,
  output logic                             last
);

  localparam int                WIDX_W   = widx_w(WORDS_PER_BLK);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS_PER_BLK - 1);

  logic [WIDX_W-1:0] word_idx_q, word_idx_d;

  assign last     = en & (word_idx_q == LAST_IDX);
  assign word_idx = word_idx_q;

  // Next word offset: clear outside bursts, advance on accepted words.
  always_comb begin
    // NOTE: default assigned first so every path drives word_idx_d and no latch is inferred.
    word_idx_d = word_idx_q;
    if (clr) begin
      word_idx_d = '0;
    end else if (en) begin
      word_idx_d = last ? '0 : word_idx_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!nRST) begin
      word_idx_q <= '0;
    end else begin
      word_idx_q <= word_idx_d;
    end
  end

endmodule

// File: rtl/dcache_ctrl_burst.sv
// Data-cache control FSM: victim writeback, line fill, snoop writeback and
// end-of-program flush walk over every {set,way} line.
module dcache_ctrl_burst
  import cache_cu_pkg::*;
#(
  parameter int WORDS_PER_BLK = 2,
  parameter int SETS          = 8,
  parameter int WAYS          = 2
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             dmemREN,
  input  logic                             dmemWEN,
  input  logic                             dhit,
  input  logic                             dirty,
  input  logic                             flush,
  input  logic                             dwait,
  input  logic                             ccwait,
  input  logic                             ccwrite,
  output logic                             dREN,
  output logic                             dWEN,
  output logic [widx_w(WORDS_PER_BLK)-1:0] word_idx,
  output logic                             fill_we,
  output logic                             line_clr,
  output logic [fidx_w(SETS, WAYS)-1:0]    flush_idx,
  output logic                             flushing,
  output logic                             halt,
  output logic                             busy
);

  localparam int                FIDX_W  = fidx_w(SETS, WAYS);
  localparam logic [FIDX_W-1:0] N_LINES = FIDX_W'(SETS * WAYS);

  dcache_state_t     state_q, state_d;
  logic [FIDX_W-1:0] flush_idx_q, flush_idx_d;
  logic              line_clr_q, line_clr_d;

  logic miss, snoop, in_burst, word_en, word_clr, word_last;

  assign miss     = (dmemREN | dmemWEN) & ~dhit;
  assign snoop    = ccwait & ccwrite;
  assign in_burst = state_q inside {WB, FILL, SNP_WB, FL_WB, FL_SNP};
  assign word_en  = in_burst & ~dwait;
  assign word_clr = ~in_burst;

  burst_word_ctr #(
    .WORDS_PER_BLK(WORDS_PER_BLK)
  ) u_word_ctr (
    .CLK     (CLK),
    .nRST    (nRST),
    .en      (word_en),
    .clr     (word_clr),
    .word_idx(word_idx),
    .last    (word_last)
  );

  // Next-state, flush index and line-clear pulse. A snoop arriving mid-burst
  // waits: the bus is ours until the burst completes.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    line_clr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (snoop) begin
          if (dirty) state_d = SNP_WB;
          else       line_clr_d = 1'b1;
        end else if (miss & ~ccwait) begin
          if (dirty) state_d = WB;
          else       state_d = FILL;
        end else if (flush) begin
          state_d = FL_CHK;
        end
      end
      WB: if (word_last) begin
        state_d    = FILL;
        line_clr_d = 1'b1;
      end
      FILL: if (word_last) state_d = IDLE;
      SNP_WB: if (word_last) begin
        state_d    = IDLE;
        line_clr_d = 1'b1;
      end
      FL_CHK: begin
        if (flush_idx_q == N_LINES) state_d = HALT;
        else if (snoop)             state_d = FL_SNP;
        else if (dirty)             state_d = FL_WB;
        else                        state_d = FL_NEXT;
      end
      FL_WB: if (word_last) begin
        state_d    = FL_NEXT;
        line_clr_d = 1'b1;
      end
      FL_SNP: if (word_last) begin
        state_d    = FL_CHK;
        line_clr_d = 1'b1;
      end
      FL_NEXT: begin
        flush_idx_d = flush_idx_q + 1'b1;
        state_d     = FL_CHK;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any burst without a line clear.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
      line_clr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      line_clr_q  <= line_clr_d;
    end
  end

  // Moore outputs from registered state; only fill_we also looks at dwait.
  assign dREN      = (state_q == FILL);
  assign dWEN      = state_q inside {WB, SNP_WB, FL_WB, FL_SNP};
  assign fill_we   = (state_q == FILL) & ~dwait;
  assign line_clr  = line_clr_q;
  assign flush_idx = flush_idx_q;
  assign flushing  = state_q inside {FL_CHK, FL_WB, FL_SNP, FL_NEXT};
  assign halt      = (state_q == HALT);
  assign busy      = (state_q != IDLE) && (state_q != HALT);

endmodule
